alu_result_tx: RTL



---
 rtl/alu_result_tx_pkg.sv | 20 ++
 rtl/alu_result_tx_baud_cnt.sv | 38 +++
 rtl/alu_result_tx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/alu_result_tx_pkg.sv
// Shared types and constants for the ALU result serial transmitter.
package alu_result_tx_pkg;

  localparam int DATA_W_DEF   = 4;
  localparam int BAUD_DIV_DEF = 4;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   FRAME_BITS = DATA_W_DEF + 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_CARRY  = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } tx_state_e;

endpackage

// File: rtl/alu_result_tx_baud_cnt.sv
// Modulo-BAUD_DIV bit timer; bit_end strikes on the last cycle of each bit.
// Shared with the receive path, so it carries no knowledge of frame layout.
module alu_tx_baud_cnt
  import alu_result_tx_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic bit_end
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_end = en && (cnt_q == LAST);

  // Next count: clear wins, otherwise wrap at LAST while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/alu_result_tx.sv
// ALU result transmitter: one-deep holding buffer plus a framed serialiser.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | line idle; starts a frame from buffer or bypass
// ST_START  | start bit
// ST_DATA   | result bits, LSB first, indexed by idx_q
// ST_CARRY  | carry-out bit
// ST_PARITY | even parity over result and carry
// ST_STOP   | stop bit; chains straight into ST_START if buffered
//
// All outputs are registered copies of the state, so the line trails the
// internal FSM by one cycle.
module alu_result_tx
  import alu_result_tx_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Load,
  input  logic [DATA_W-1:0] Result,
  input  logic              Carry,
  output logic              Ready,
  output logic              Busy,
  output logic              Tx,
  output logic              Done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              carry_q, carry_d;
  logic              par_q, par_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic              buf_carry_q, buf_carry_d;
  logic              buf_full_q, buf_full_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              bit_end;
  logic              accept;
  logic              in_frame;
  logic              load_en;
  logic [DATA_W-1:0] load_data;
  logic              load_carry;

  assign accept   = Load && !buf_full_q;
  assign in_frame = (state_q != ST_IDLE);

  alu_tx_baud_cnt #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .Clk     (Clk),
    .Reset   (Reset),
    .clr     (!in_frame),
    .en      (in_frame),
    .bit_end (bit_end)
  );

  // Frame sequencing, buffer bookkeeping and next values of the line outputs.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    carry_d     = carry_q;
    par_d       = par_q;
    idx_d       = idx_q;
    buf_data_d  = buf_data_q;
    buf_carry_d = buf_carry_q;
    buf_full_d  = buf_full_q;
    load_en     = 1'b0;
    load_data   = buf_data_q;
    load_carry  = buf_carry_q;

    case (state_q)
      ST_IDLE: begin
        if (buf_full_q) begin
          load_en    = 1'b1;
          buf_full_d = 1'b0;
        end else if (accept) begin
          load_en    = 1'b1;
          load_data  = Result;
          load_carry = Carry;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_CARRY;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_CARRY: begin
        if (bit_end) state_d = ST_PARITY;
      end
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) begin
          if (buf_full_q) begin
            load_en    = 1'b1;
            buf_full_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_en) begin
      state_d = ST_START;
      idx_d   = '0;
      data_d  = load_data;
      carry_d = load_carry;
      par_d   = (^load_data) ^ load_carry;
    end

    // While a frame is running, accepts park in the buffer. Accept needs an
    // empty buffer, so it never collides with a drain in the same cycle.
    if (accept && in_frame) begin
      buf_data_d  = Result;
      buf_carry_d = Carry;
      buf_full_d  = 1'b1;
    end

    case (state_q)
      ST_START:  tx_d = START_BIT;
      ST_DATA:   tx_d = data_q[idx_q];
      ST_CARRY:  tx_d = carry_q;
      ST_PARITY: tx_d = par_q;
      default:   tx_d = STOP_BIT;
    endcase
    busy_d = in_frame;
    done_d = (state_q == ST_STOP) && bit_end;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      carry_q     <= 1'b0;
      par_q       <= 1'b0;
      idx_q       <= '0;
      buf_data_q  <= '0;
      buf_carry_q <= 1'b0;
      buf_full_q  <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      carry_q     <= carry_d;
      par_q       <= par_d;
      idx_q       <= idx_d;
      buf_data_q  <= buf_data_d;
      buf_carry_q <= buf_carry_d;
      buf_full_q  <= buf_full_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign Ready = !buf_full_q;
  assign Busy  = busy_q;
  assign Tx    = tx_q;
  assign Done  = done_q;

endmodule
